// File: rtl/mult_32bit_arbiter.sv
// ---------------------------------------------------------------------------
// mult_32bit_arbiter
//
// Shares a single 32x32 hard multiplier between NUM_REQ requesters using
// round-robin arbitration. One multiplication is in flight at a time:
// operands are accepted over a valid/ready handshake, held on Amult/Bmult
// with Valid_mult high for MULT_LATENCY+1 cycles, the product is captured
// from Cmult and returned to the granted requester over valid/ready.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   MULT_LATENCY  extra cycles Cmult needs after Amult/Bmult are stable (0..3)
//
// Ports
//   Clk         clock, rising edge
//   Reset       asynchronous, active-high reset
//   Req_valid   per-requester operand valid
//   Req_ready   one-hot accept strobe (combinational, IDLE only)
//   Req_A/Req_B packed operands, requester i in bits [32i+31:32i]
//   Res_valid   one-hot registered result valid
//   Res_ready   per-requester result consume
//   Res_data    registered 64-bit product
//   Amult/Bmult operands to the multiplier (zero outside EXEC)
//   Valid_mult  multiplier enable (high only in EXEC)
//   Cmult       product from the multiplier
//   Busy        high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mult_32bit_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int MULT_LATENCY = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      Req_valid,
  output logic [NUM_REQ-1:0]      Req_ready,
  input  logic [32*NUM_REQ-1:0]   Req_A,
  input  logic [32*NUM_REQ-1:0]   Req_B,
  output logic [NUM_REQ-1:0]      Res_valid,
  input  logic [NUM_REQ-1:0]      Res_ready,
  output logic [63:0]             Res_data,
  output logic [31:0]             Amult,
  output logic [31:0]             Bmult,
  output logic                    Valid_mult,
  input  logic [63:0]             Cmult,
  output logic                    Busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [31:0]        opa_reg, opb_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [63:0]        res_data_reg;
  logic [NUM_REQ-1:0] res_valid_reg;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  // Unpacked views of the packed operand buses.
  logic [31:0] req_a [NUM_REQ];
  logic [31:0] req_b [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a[gi] = Req_A[32*gi +: 32];
    assign req_b[gi] = Req_B[32*gi +: 32];
  end

  // Round-robin pick: first asserted request searching upward from the
  // requester after the last one served, wrapping around.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_reg) + 1 + k) % NUM_REQ;
      if (!pick_found && Req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Next state and the combinational accept strobe.
  always_comb begin
    state_next = state_reg;
    Req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          Req_ready[pick_idx] = 1'b1;
          state_next          = EXEC;
        end
      end
      EXEC: begin
        if (cnt_reg == '0) state_next = RESP;
      end
      RESP: begin
        // Only the granted requester's consume bit matters.
        if (Res_ready[grant_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
      grant_reg     <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      cnt_reg       <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_idx;
            opa_reg   <= req_a[pick_idx];
            opb_reg   <= req_b[pick_idx];
            cnt_reg   <= CNT_W'(MULT_LATENCY);
          end
        end
        EXEC: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            res_data_reg  <= Cmult;
            res_valid_reg <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_reg;
          end
        end
        RESP: begin
          if (Res_ready[grant_reg]) begin
            res_valid_reg <= '0;
            ptr_reg       <= grant_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // The macro only sees operands while a multiplication is running.
  assign Amult      = (state_reg == EXEC) ? opa_reg : 32'd0;
  assign Bmult      = (state_reg == EXEC) ? opb_reg : 32'd0;
  assign Valid_mult = (state_reg == EXEC);
  assign Busy       = (state_reg != IDLE);
  assign Res_valid  = res_valid_reg;
  assign Res_data   = res_data_reg;

endmodule
